serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: one full-adder slice, built from two halfadder instances plus an OR for carry, is time-shared across all WIDTH bit positions of an operand pair.
- Processes one bit per clock, LSB first, under a start/ready/done handshake.
- Used where area matters more than latency, e.g. accumulator updates in slow control paths.
- The full-adder slice is internal to this block; the sequencing FSM, operand shift registers and carry flop are this block's deliverable.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to add; accepted only when ready=1.
- A  input  WIDTH  operand A; sampled on the accepting edge only.
- B  input  WIDTH  operand B; sampled on the accepting edge only.
- Cin  input  1  carry-in; sampled on the accepting edge only.
- ready  output  1  high in IDLE; block can accept start.
- SUM  output  WIDTH  registered result; updated only at completion, held otherwise.
- Cout  output  1  registered final carry-out; updated with SUM.
- done  output  1  one-cycle pulse marking that SUM/Cout were just updated.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state=IDLE, ready=1, done=0, SUM=0, Cout=0.
  - Internal shift registers, carry flop and counter are cleared.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN.
- IDLE:
  - ready=1.
  - On the edge where start=1: load shA<=A, shB<=B, carry<=Cin, cnt<=0, state<=RUN.
  - start=0: remain in IDLE.
- RUN:
  - ready=0.
  - Each edge: bit s=shA[0]^shB[0]^carry is shifted into the result shift register at its MSB end (the register shifts right).
  - Same edge: carry<=(shA[0]&shB[0])|(carry&(shA[0]^shB[0])); shA and shB shift right by 1; cnt increments.
  - The edge that processes bit WIDTH-1 (cnt=WIDTH-1):
    - SUM<={s, resultshift[WIDTH-1:1]}, i.e. the final word.
    - Cout<=final carry.
    - done<=1; state<=IDLE.
- Latency:
  - start accepted at edge k; bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
  - SUM/Cout/done become valid after edge k+WIDTH; done deasserts after edge k+WIDTH+1 unless a new completion occurs.
  - Throughput: one add per WIDTH+1 cycles.
- start while ready=0 is ignored. No queuing; A/B/Cin may change freely during RUN.
- Back-to-back: ready is 1 in the cycle where done=1. start in that cycle is accepted, and done still drops on the next edge.
- SUM/Cout hold their last result through IDLE and the whole of the next RUN; they never show partial bits.
- Arithmetic: {Cout,SUM} = A + B + Cin, modulo 2^(WIDTH+1); unsigned.
- Reset mid-RUN aborts the operation. Outputs return to their reset values, and no done pulse is produced for the aborted add.
- X on start while ready=1 is a bench error; the design need not define the behaviour.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C, Cin=0, start one cycle -> ready low for 8 cycles; done single pulse at edge k+8; SUM=0x96, Cout=0.
- A=0xFF, B=0x01, Cin=0 -> SUM=0x00, Cout=1 (full carry ripple through all bits).
- A=0xFF, B=0xFF, Cin=1 -> SUM=0xFF, Cout=1; then A=0x00, B=0x00, Cin=0 -> SUM=0x00, Cout=0 (carry flop cleared by load).
- Start 0x12+0x34, then pulse start with 0xAA+0x55 at cycle k+3 -> second start ignored; SUM=0x46, Cout=0; SUM unchanged before edge k+8.
- Back-to-back: start 0x01+0x01, then start 0x80+0x80 held during the done cycle -> first SUM=0x02; second accepted immediately; done pulses at k+8 and k+17; final SUM=0x00, Cout=1.
- rst_n low at cycle k+4 of 0x0F+0x01 -> ready=1, SUM=0, Cout=0, done=0 immediately (async); no done pulse afterwards; a new add after release completes correctly.

Source files
------------

// File: rtl/serial_add_ctrl.sv
//==============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder, one bit per clock, LSB first, start/ready/done.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_add_halfadder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             ready,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout,
    output logic             done
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(WIDTH - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;

    logic w_ready;
    logic w_load;
    logic w_step;
    logic w_last;

    // Time-shared full-adder slice: two half adders plus carry OR
    logic w_p;
    logic w_g0;
    logic w_g1;
    logic w_s;
    logic w_c;

    serial_add_halfadder u_ha0 (
        .i_a (r_sh_a[0]),
        .i_b (r_sh_b[0]),
        .o_s (w_p),
        .o_c (w_g0)
    );

    serial_add_halfadder u_ha1 (
        .i_a (w_p),
        .i_b (r_carry),
        .o_s (w_s),
        .o_c (w_g1)
    );

    assign w_c = w_g0 | w_g1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (r_cnt == c_LAST) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_load  = 1'b0;
        w_step  = 1'b0;
        w_last  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_ready = 1'b1;
                w_load  = start;
            end
            c_ST_RUN: begin
                w_step = 1'b1;
                w_last = (r_cnt == c_LAST);
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // Result word is only published on the final bit so SUM never shows partial bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_sh_a  <= A;
                r_sh_b  <= B;
                r_carry <= Cin;
                r_res   <= '0;
                r_cnt   <= '0;
            end else if (w_step) begin
                r_sh_a  <= r_sh_a >> 1;
                r_sh_b  <= r_sh_b >> 1;
                r_res   <= {w_s, r_res[WIDTH-1:1]};
                r_carry <= w_c;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_sum  <= {w_s, r_res[WIDTH-1:1]};
                    r_cout <= w_c;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign ready = w_ready;
    assign SUM   = r_sum;
    assign Cout  = r_cout;
    assign done  = r_done;

endmodule

`default_nettype wire
